// File: rtl/spi_slave_00_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_00_if
// Description : Pin and byte-side bundle for the mode-0 SPI responder.
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_slave_00_if;
  logic       ss;
  logic       sck;
  logic       mosi;
  logic [7:0] data_in;
  logic       miso;
  logic       miso_oe;
  logic       busy;
  logic       new_data;
  logic [7:0] data_out;

  modport slave (
    input  ss, sck, mosi, data_in,
    output miso, miso_oe, busy, new_data, data_out
  );

  modport master (
    output ss, sck, mosi, data_in,
    input  miso, miso_oe, busy, new_data, data_out
  );
endinterface
`default_nettype wire

// File: rtl/spi_slave_00.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_00
// Description : SPI mode-0 responder, MSB first, 8-bit frames, pins oversampled.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_00 (
  input  wire           clk,
  input  wire           rst,
  spi_slave_00_if.slave bus
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  localparam logic [2:0] c_LAST_BIT = 3'd7;

  logic       r_ss_s1, r_ss_s2, r_ss_s3;
  logic       r_sck_s1, r_sck_s2, r_sck_s3;
  logic       r_mosi_s1, r_mosi_s2;
  logic [1:0] r_fill;
  logic       r_armed;
  state_t     r_state;
  logic [7:0] r_tx;
  logic [7:0] r_rx;
  logic [2:0] r_ctr;
  logic [7:0] r_data_out;
  logic       r_new_data;

  state_t     w_state_nxt;
  logic [7:0] w_tx_nxt;
  logic [7:0] w_rx_nxt;
  logic [2:0] w_ctr_nxt;
  logic [7:0] w_data_out_nxt;
  logic       w_new_data_nxt;

  logic w_ss_rise, w_ss_fall, w_sck_rise, w_sck_fall, w_sync_valid;

  assign w_ss_rise    =  r_ss_s2  & ~r_ss_s3;
  assign w_ss_fall    = ~r_ss_s2  &  r_ss_s3;
  assign w_sck_rise   =  r_sck_s2 & ~r_sck_s3;
  assign w_sck_fall   = ~r_sck_s2 &  r_sck_s3;
  // The ss chain resets high, so its stage 2 only reflects the pin once two
  // edges have passed; arming before then would let a held-low ss start a frame.
  assign w_sync_valid = (r_fill == 2'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ss_s1    <= 1'b1;
      r_ss_s2    <= 1'b1;
      r_ss_s3    <= 1'b1;
      r_sck_s1   <= 1'b0;
      r_sck_s2   <= 1'b0;
      r_sck_s3   <= 1'b0;
      r_mosi_s1  <= 1'b0;
      r_mosi_s2  <= 1'b0;
      r_fill     <= 2'd0;
      r_armed    <= 1'b0;
      r_state    <= ST_IDLE;
      r_tx       <= 8'h00;
      r_rx       <= 8'h00;
      r_ctr      <= 3'd0;
      r_data_out <= 8'h00;
      r_new_data <= 1'b0;
    end else begin
      r_ss_s1    <= bus.ss;
      r_ss_s2    <= r_ss_s1;
      r_ss_s3    <= r_ss_s2;
      r_sck_s1   <= bus.sck;
      r_sck_s2   <= r_sck_s1;
      r_sck_s3   <= r_sck_s2;
      r_mosi_s1  <= bus.mosi;
      r_mosi_s2  <= r_mosi_s1;
      r_fill     <= w_sync_valid ? r_fill : r_fill + 2'd1;
      r_armed    <= r_armed | (w_sync_valid & r_ss_s2);
      r_state    <= w_state_nxt;
      r_tx       <= w_tx_nxt;
      r_rx       <= w_rx_nxt;
      r_ctr      <= w_ctr_nxt;
      r_data_out <= w_data_out_nxt;
      r_new_data <= w_new_data_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_tx_nxt       = r_tx;
    w_rx_nxt       = r_rx;
    w_ctr_nxt      = r_ctr;
    w_data_out_nxt = r_data_out;
    w_new_data_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ctr_nxt = 3'd0;
        if (w_ss_fall && r_armed) begin
          w_tx_nxt    = bus.data_in;
          w_state_nxt = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (w_ss_rise) begin
          w_state_nxt = ST_IDLE;
          w_ctr_nxt   = 3'd0;
        end else if (w_sck_rise) begin
          w_rx_nxt  = {r_rx[6:0], r_mosi_s2};
          w_ctr_nxt = r_ctr + 3'd1;
          if (r_ctr == c_LAST_BIT) begin
            w_data_out_nxt = {r_rx[6:0], r_mosi_s2};
            w_new_data_nxt = 1'b1;
          end
        end else if (w_sck_fall) begin
          // ctr has wrapped to 0 only just after the 8th rise: reload next byte
          w_tx_nxt = (r_ctr == 3'd0) ? bus.data_in : {r_tx[6:0], 1'b0};
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign bus.miso     = (r_state == ST_ACTIVE) ? r_tx[7] : 1'b0;
  assign bus.miso_oe  = (r_state == ST_ACTIVE);
  assign bus.busy     = (r_state == ST_ACTIVE);
  assign bus.new_data = r_new_data;
  assign bus.data_out = r_data_out;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_00.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_slave_00
// Description : Directed bench for spi_slave_00 with a received-byte scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave_00;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  logic [7:0] sb[$];
  logic [7:0] mi;

  spi_slave_00_if bus();

  spi_slave_00 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Master side of one byte: mosi set while sck low, miso sampled as sck rises.
  task automatic xfer(input logic [7:0] mo, input int nbits, input int h,
                      input logic [7:0] din_next, input bit last_fall,
                      output logic [7:0] mi_out);
    logic [7:0] acc;
    acc = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      bus.mosi = mo[7-i];
      wait_clk(h);
      bus.sck = 1'b1;
      acc = {acc[6:0], bus.miso};
      if (i == nbits - 1) bus.data_in = din_next;
      if (i < nbits - 1 || last_fall) begin
        wait_clk(h);
        bus.sck = 1'b0;
      end
    end
    mi_out = acc;
  endtask

  always @(negedge clk) begin
    if (!rst && bus.new_data) begin
      check("pulse_expected", logic'(sb.size() != 0), 8'h01);
      if (sb.size() != 0) check("data_out", bus.data_out, sb.pop_front());
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_miso"},     {7'd0, bus.miso},     8'h00);
    check({tag, "_miso_oe"},  {7'd0, bus.miso_oe},  8'h00);
    check({tag, "_busy"},     {7'd0, bus.busy},     8'h00);
    check({tag, "_new_data"}, {7'd0, bus.new_data}, 8'h00);
    check({tag, "_data_out"}, bus.data_out,         8'h00);
  endtask

  initial begin
    rst = 1'b1;
    bus.ss = 1'b1; bus.sck = 1'b0; bus.mosi = 1'b0; bus.data_in = 8'h00;
    wait_clk(3);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Single byte, 8-clk sck period
    bus.data_in = 8'hA5;
    wait_clk(10);
    bus.ss = 1'b0;
    sb.push_back(8'h3C);
    xfer(8'h3C, 8, 4, 8'hA5, 1'b1, mi);
    check("t1_miso_byte", mi, 8'hA5);
    wait_clk(4);
    check("t1_busy_active", {7'd0, bus.busy}, 8'h01);
    bus.ss = 1'b1;
    wait_clk(6);
    check("t1_busy_idle", {7'd0, bus.busy}, 8'h00);
    check("t1_sb_empty", logic'(sb.size() == 0), 8'h01);

    // Back-to-back bytes, data_in switched before the 8th fall of byte 1
    bus.data_in = 8'h80;
    wait_clk(6);
    bus.ss = 1'b0;
    sb.push_back(8'h01);
    sb.push_back(8'hFF);
    xfer(8'h01, 8, 5, 8'h7E, 1'b1, mi);
    check("t2_miso_byte1", mi, 8'h80);
    xfer(8'hFF, 8, 5, 8'h7E, 1'b1, mi);
    check("t2_miso_byte2", mi, 8'h7E);
    wait_clk(5);
    bus.ss = 1'b1;
    wait_clk(6);
    check("t2_data_out", bus.data_out, 8'hFF);
    check("t2_sb_empty", logic'(sb.size() == 0), 8'h01);

    // Abort after 5 rises, then a full frame
    bus.data_in = 8'h33;
    bus.ss = 1'b0;
    xfer(8'hA0, 5, 5, 8'h33, 1'b1, mi);
    wait_clk(5);
    bus.ss = 1'b1;
    wait_clk(6);
    check("t3_abort_data_out", bus.data_out, 8'hFF);
    check("t3_abort_miso_oe", {7'd0, bus.miso_oe}, 8'h00);
    bus.data_in = 8'h69;
    wait_clk(4);
    bus.ss = 1'b0;
    sb.push_back(8'h5A);
    xfer(8'h5A, 8, 5, 8'h69, 1'b1, mi);
    check("t3_miso_byte", mi, 8'h69);
    wait_clk(5);
    bus.ss = 1'b1;
    wait_clk(6);
    check("t3_sb_empty", logic'(sb.size() == 0), 8'h01);

    // Minimum sck high/low of 4 clk
    bus.data_in = 8'hC3;
    wait_clk(4);
    bus.ss = 1'b0;
    sb.push_back(8'h55);
    xfer(8'h55, 8, 4, 8'hC3, 1'b1, mi);
    check("t4_miso_byte", mi, 8'hC3);
    wait_clk(4);
    bus.ss = 1'b1;
    wait_clk(6);
    check("t4_data_out", bus.data_out, 8'h55);

    // ss rise together with the 8th sck rise
    bus.data_in = 8'h0F;
    bus.ss = 1'b0;
    xfer(8'hC4, 7, 4, 8'h0F, 1'b1, mi);
    bus.mosi = 1'b0;
    wait_clk(4);
    bus.sck = 1'b1;
    bus.ss  = 1'b1;
    wait_clk(8);
    bus.sck = 1'b0;
    wait_clk(6);
    check("t5_data_out", bus.data_out, 8'h55);
    check("t5_busy", {7'd0, bus.busy}, 8'h00);

    // Reset mid-frame with ss held low
    bus.data_in = 8'hE7;
    bus.ss = 1'b0;
    xfer(8'hB2, 3, 4, 8'hE7, 1'b1, mi);
    rst = 1'b1;
    wait_clk(3);
    check_reset_outputs("t6_in_reset");
    rst = 1'b0;
    wait_clk(4);
    xfer(8'hFF, 8, 4, 8'hE7, 1'b1, mi);
    wait_clk(4);
    check("t6_no_start_busy", {7'd0, bus.busy}, 8'h00);
    check("t6_no_start_data_out", bus.data_out, 8'h00);
    bus.ss = 1'b1;
    wait_clk(10);
    bus.data_in = 8'h3A;
    bus.ss = 1'b0;
    sb.push_back(8'h96);
    xfer(8'h96, 8, 4, 8'h3A, 1'b1, mi);
    check("t6_miso_byte", mi, 8'h3A);
    wait_clk(4);
    bus.ss = 1'b1;
    wait_clk(6);
    check("t6_data_out", bus.data_out, 8'h96);
    check("t6_sb_empty", logic'(sb.size() == 0), 8'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
